multicycle_control_unit: RTL and testbench

Moore-FSM controller for the multicycle MIPS datapath. It replaces the combinational single-cycle controller and sequences each instruction over 3–5 cycles, sharing one ALU and one unified instruction/data memory. An optional memory ready handshake supports multi-cycle memory accesses. Adds `addi` and `j` support and flags illegal opcodes. It sits between the instruction register (opcode/funct), the ALU Zero flag, and every datapath mux select and write enable.

---
 rtl/mips_ctrl_pkg.sv | 43 ++++
 rtl/mc_alu_decoder.sv | 36 +++
 rtl/multicycle_control_unit.sv | 165 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// ALUOp and ALU control codes, and the FSM state enum.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU decoder: ALUOp + Funct -> ALUControl, zero-extended to ALUCTRL_W.
module mc_alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 3
) (
  input  logic [1:0]           i_alu_op,
  input  logic [5:0]           i_funct,
  output logic [ALUCTRL_W-1:0] o_alu_control
);

  logic [2:0] w_code;

  // Select the 3-bit ALU operation; unknown funct and ALUOp 11 fall back to add
  always_comb begin
    w_code = ALUC_ADD;
    case (i_alu_op)
      ALUOP_ADD: w_code = ALUC_ADD;
      ALUOP_SUB: w_code = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          F_ADD:   w_code = ALUC_ADD;
          F_SUB:   w_code = ALUC_SUB;
          F_AND:   w_code = ALUC_AND;
          F_OR:    w_code = ALUC_OR;
          F_SLT:   w_code = ALUC_SLT;
          default: w_code = ALUC_ADD;
        endcase
      end
      default: w_code = ALUC_ADD;
    endcase
  end

  assign o_alu_control = ALUCTRL_W'(w_code);

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM controller for the multicycle MIPS datapath with optional
// memory ready handshake; outputs decode combinationally from the state.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W     = 3,
  parameter int unsigned USE_MEM_READY = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           Opcode,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 MemtoReg,
  output logic                 RegDst,
  output logic                 IorD,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           PCSrc,
  output logic                 IRWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 PCEn,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 illegal_op,
  output logic                 instr_done,
  output logic [3:0]           state_o
);

  state_t     r_state;
  logic       w_rdy;
  logic       w_op_legal;
  logic [1:0] w_alu_op;
  logic       w_pc_write;
  logic       w_branch;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_illegal;
  logic       w_done;

  assign w_rdy = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

  // Classify the opcode currently held in the instruction register
  always_comb begin
    case (Opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_op_legal = 1'b1;
      default:                                      w_op_legal = 1'b0;
    endcase
  end

  // State register: sequence instructions, holding memory states until ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      case (r_state)
        FETCH:    if (w_rdy) r_state <= DECODE;
        DECODE: begin
          case (Opcode)
            OP_LW, OP_SW: r_state <= MEMADR;
            OP_RTYPE:     r_state <= EXECUTE;
            OP_BEQ:       r_state <= BRANCH;
            OP_ADDI:      r_state <= ADDIEX;
            OP_J:         r_state <= JUMP;
            default:      r_state <= FETCH;
          endcase
        end
        MEMADR:   r_state <= (Opcode == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:  if (w_rdy) r_state <= MEMWB;
        MEMWRITE: if (w_rdy) r_state <= FETCH;
        EXECUTE:  r_state <= ALUWB;
        ADDIEX:   r_state <= ADDIWB;
        default:  r_state <= FETCH;
      endcase
    end
  end

  // Per-state output decode; strobes on memory states are qualified by ready
  always_comb begin
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    IorD        = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 2'b00;
    w_alu_op    = ALUOP_ADD;
    w_pc_write  = 1'b0;
    w_branch    = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      FETCH: begin
        ALUSrcB    = 2'b01;
        w_ir_write = w_rdy;
        w_pc_write = w_rdy;
      end
      DECODE: begin
        ALUSrcB   = 2'b11;
        w_illegal = ~w_op_legal;
      end
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMREAD: IorD = 1'b1;
      MEMWRITE: begin
        IorD        = 1'b1;
        w_mem_write = w_rdy;
        w_done      = w_rdy;
      end
      MEMWB: begin
        w_reg_write = 1'b1;
        MemtoReg    = 1'b1;
        w_done      = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA  = 1'b1;
        w_alu_op = ALUOP_FUNCT;
      end
      ALUWB: begin
        RegDst      = 1'b1;
        w_reg_write = 1'b1;
        w_done      = 1'b1;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        w_alu_op = ALUOP_SUB;
        PCSrc    = 2'b01;
        w_branch = 1'b1;
        w_done   = 1'b1;
      end
      ADDIWB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
      end
      JUMP: begin
        PCSrc      = 2'b10;
        w_pc_write = 1'b1;
        w_done     = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables and status pulses are suppressed while reset is held
  assign IRWrite    = w_ir_write  & ~reset;
  assign MemWrite   = w_mem_write & ~reset;
  assign RegWrite   = w_reg_write & ~reset;
  assign PCEn       = (w_pc_write | (w_branch & Zero)) & ~reset;
  assign illegal_op = w_illegal   & ~reset;
  assign instr_done = w_done      & ~reset;
  assign state_o    = r_state;

  mc_alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
    .i_alu_op      (w_alu_op),
    .i_funct       (Funct),
    .o_alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: one instance ignoring
// mem_ready (a_*) and one honouring it (b_*), sharing all inputs.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode, Funct;
  logic       Zero, mem_ready;

  logic       a_MemtoReg, a_RegDst, a_IorD, a_ALUSrcA, a_IRWrite, a_MemWrite, a_RegWrite, a_PCEn;
  logic       a_illegal, a_done;
  logic [1:0] a_ALUSrcB, a_PCSrc;
  logic [2:0] a_ALUControl;
  logic [3:0] a_state;

  logic       b_MemtoReg, b_RegDst, b_IorD, b_ALUSrcA, b_IRWrite, b_MemWrite, b_RegWrite, b_PCEn;
  logic       b_illegal, b_done;
  logic [1:0] b_ALUSrcB, b_PCSrc;
  logic [2:0] b_ALUControl;
  logic [3:0] b_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.ALUCTRL_W(3), .USE_MEM_READY(0)) u_a (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .MemtoReg(a_MemtoReg), .RegDst(a_RegDst), .IorD(a_IorD), .ALUSrcA(a_ALUSrcA),
    .ALUSrcB(a_ALUSrcB), .PCSrc(a_PCSrc), .IRWrite(a_IRWrite), .MemWrite(a_MemWrite),
    .RegWrite(a_RegWrite), .PCEn(a_PCEn), .ALUControl(a_ALUControl),
    .illegal_op(a_illegal), .instr_done(a_done), .state_o(a_state)
  );

  multicycle_control_unit #(.ALUCTRL_W(3), .USE_MEM_READY(1)) u_b (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .MemtoReg(b_MemtoReg), .RegDst(b_RegDst), .IorD(b_IorD), .ALUSrcA(b_ALUSrcA),
    .ALUSrcB(b_ALUSrcB), .PCSrc(b_PCSrc), .IRWrite(b_IRWrite), .MemWrite(b_MemWrite),
    .RegWrite(b_RegWrite), .PCEn(b_PCEn), .ALUControl(b_ALUControl),
    .illegal_op(b_illegal), .instr_done(b_done), .state_o(b_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; Opcode = 6'b000000; Funct = 6'b000000; Zero = 1'b0; mem_ready = 1'b1;
    #1;
    // Reset state: FETCH, enables forced low, selects at FETCH values
    chk("rst_state", a_state, 4'd0);
    chk("rst_irwrite", a_IRWrite, 1'b0);
    chk("rst_pcen", a_PCEn, 1'b0);
    chk("rst_alusrcb", a_ALUSrcB, 2'b01);
    chk("rst_aluctl", a_ALUControl, 3'b010);
    do_reset();

    // lw, no wait states: 0,1,2,3,4 then FETCH
    Opcode = 6'b100011; #1;
    chk("lw_fetch_state", a_state, 4'd0);
    chk("lw_fetch_irwrite", a_IRWrite, 1'b1);
    chk("lw_fetch_pcen", a_PCEn, 1'b1);
    step();
    chk("lw_decode_state", a_state, 4'd1);
    chk("lw_decode_alusrcb", a_ALUSrcB, 2'b11);
    chk("lw_decode_irwrite", a_IRWrite, 1'b0);
    step();
    chk("lw_memadr_state", a_state, 4'd2);
    chk("lw_memadr_srcb", a_ALUSrcB, 2'b10);
    chk("lw_memadr_srca", a_ALUSrcA, 1'b1);
    step();
    chk("lw_memread_state", a_state, 4'd3);
    chk("lw_memread_iord", a_IorD, 1'b1);
    chk("lw_memread_regwrite", a_RegWrite, 1'b0);
    chk("lw_memread_done", a_done, 1'b0);
    step();
    chk("lw_memwb_state", a_state, 4'd4);
    chk("lw_memwb_regwrite", a_RegWrite, 1'b1);
    chk("lw_memwb_memtoreg", a_MemtoReg, 1'b1);
    chk("lw_memwb_done", a_done, 1'b1);
    step();
    chk("lw_end_state", a_state, 4'd0);
    chk("lw_end_done", a_done, 1'b0);

    // Reset asserted mid-MEMREAD
    step(); step(); step();
    chk("mid_memread_state", a_state, 4'd3);
    reset = 1'b1; #1;
    chk("mid_rst_state", a_state, 4'd0);
    chk("mid_rst_state_b", b_state, 4'd0);
    chk("mid_rst_iord", a_IorD, 1'b0);
    step();
    chk("mid_rst_hold_state", a_state, 4'd0);
    chk("mid_rst_irwrite", a_IRWrite, 1'b0);
    chk("mid_rst_pcen", a_PCEn, 1'b0);
    chk("mid_rst_regwrite", a_RegWrite, 1'b0);
    reset = 1'b0; #1;
    chk("rel_state", a_state, 4'd0);
    chk("rel_irwrite", a_IRWrite, 1'b1);
    step();
    chk("rel_first_edge", a_state, 4'd1);
    do_reset();

    // R-type slt
    Opcode = 6'b000000; Funct = 6'b101010; #1;
    step();
    chk("slt_decode", a_state, 4'd1);
    step();
    chk("slt_exec_state", a_state, 4'd6);
    chk("slt_exec_aluctl", a_ALUControl, 3'b111);
    chk("slt_exec_srcb", a_ALUSrcB, 2'b00);
    step();
    chk("slt_aluwb_state", a_state, 4'd7);
    chk("slt_aluwb_regdst", a_RegDst, 1'b1);
    chk("slt_aluwb_regwrite", a_RegWrite, 1'b1);
    chk("slt_aluwb_done", a_done, 1'b1);
    step();
    chk("slt_end", a_state, 4'd0);

    // R-type and: EXECUTE ALUControl 000
    Funct = 6'b100100; #1;
    step(); step();
    chk("and_exec_aluctl", a_ALUControl, 3'b000);
    step(); step();

    // beq taken
    Opcode = 6'b000100; Zero = 1'b1; #1;
    step(); step();
    chk("beqt_state", a_state, 4'd8);
    chk("beqt_pcen", a_PCEn, 1'b1);
    chk("beqt_pcsrc", a_PCSrc, 2'b01);
    chk("beqt_aluctl", a_ALUControl, 3'b110);
    chk("beqt_done", a_done, 1'b1);
    step();
    chk("beqt_end", a_state, 4'd0);

    // beq not taken
    Zero = 1'b0; #1;
    step(); step();
    chk("beqn_state", a_state, 4'd8);
    chk("beqn_pcen", a_PCEn, 1'b0);
    step();
    chk("beqn_end", a_state, 4'd0);

    // Illegal opcode followed by j
    Opcode = 6'b111111; #1;
    step();
    chk("ill_state", a_state, 4'd1);
    chk("ill_flag", a_illegal, 1'b1);
    chk("ill_regwrite", a_RegWrite, 1'b0);
    chk("ill_memwrite", a_MemWrite, 1'b0);
    step();
    chk("ill_next", a_state, 4'd0);
    chk("ill_flag_clr", a_illegal, 1'b0);
    Opcode = 6'b000010; #1;
    step();
    chk("j_decode_noillegal", a_illegal, 1'b0);
    step();
    chk("j_state", a_state, 4'd11);
    chk("j_pcsrc", a_PCSrc, 2'b10);
    chk("j_pcen", a_PCEn, 1'b1);
    chk("j_done", a_done, 1'b1);
    step();
    chk("j_end", a_state, 4'd0);

    // addi
    Opcode = 6'b001000; #1;
    step(); step();
    chk("addi_ex_state", a_state, 4'd9);
    chk("addi_ex_srcb", a_ALUSrcB, 2'b10);
    step();
    chk("addi_wb_state", a_state, 4'd10);
    chk("addi_wb_regwrite", a_RegWrite, 1'b1);
    chk("addi_wb_regdst", a_RegDst, 1'b0);
    step();
    chk("addi_end", a_state, 4'd0);
    do_reset();

    // Ready-gated sw: MEMWRITE waits three cycles on mem_ready
    Opcode = 6'b101011; #1;
    step(); step(); step();
    chk("sw_b_memwrite_state", b_state, 4'd5);
    mem_ready = 1'b0; #1;
    chk("sw_a_ignores_ready", a_MemWrite, 1'b1);
    for (int unsigned i = 0; i < 3; i++) begin
      chk("sw_wait_state", b_state, 4'd5);
      chk("sw_wait_memwrite", b_MemWrite, 1'b0);
      chk("sw_wait_iord", b_IorD, 1'b1);
      chk("sw_wait_done", b_done, 1'b0);
      step();
    end
    mem_ready = 1'b1; #1;
    chk("sw_ready_memwrite", b_MemWrite, 1'b1);
    chk("sw_ready_done", b_done, 1'b1);
    step();
    chk("sw_end_state", b_state, 4'd0);
    chk("sw_end_memwrite", b_MemWrite, 1'b0);

    // FETCH wait on mem_ready
    mem_ready = 1'b0; #1;
    chk("fwait_irwrite", b_IRWrite, 1'b0);
    chk("fwait_pcen", b_PCEn, 1'b0);
    chk("fwait_srcb", b_ALUSrcB, 2'b01);
    step();
    chk("fwait_hold", b_state, 4'd0);
    mem_ready = 1'b1; #1;
    chk("fwait_irwrite_go", b_IRWrite, 1'b1);
    step();
    chk("fwait_decode", b_state, 4'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
